// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule types: controller state enum and
// the word-index constants of the 64-word message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } state_t;

  localparam int W_FIRST_EXP = 16;
  localparam int W_LAST      = 63;
  localparam int W_LENGTH    = 64;

endpackage

// File: rtl/w_index_counter.sv
// Expansion word-index counter: clear, load-to-first, increment.
// Ports: clock, reset, clear, load, inc -> count, last (count==LAST_VAL).
module w_index_counter
  import sha256_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int LOAD_VAL = W_FIRST_EXP,
  parameter int LAST_VAL = W_LAST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(LAST_VAL + 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= WIDTH'(LOAD_VAL);
    end else if (inc && count != TOP) begin
      // saturate one past the last word so the index never overruns
      count <= count + WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(LAST_VAL));

endmodule

// File: rtl/w_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: load W0..W15, expand 16..63, hold.
// Ports: clock/reset, msg_valid/msg_ready, load_block, exp_*, abort,
// w_ready/w_ack, busy, blocks_done (acknowledged schedules, wraps).
module w_schedule_ctrl #(
  parameter int W_LENGTH    = 64,
  parameter int BLOCK_WORDS = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         msg_valid,
  output logic                         msg_ready,
  output logic                         load_block,
  output logic                         exp_enable,
  output logic [$clog2(W_LENGTH):0]    exp_index,
  output logic                         exp_index_complete,
  input  logic                         abort,
  output logic                         w_ready,
  input  logic                         w_ack,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         blocks_done
);

  import sha256_pkg::*;

  localparam int IW = $clog2(W_LENGTH) + 1;

  state_t        state;
  logic [IW-1:0] index;
  logic          idx_last;
  logic          accept;
  logic          drop;
  logic          retire;

  assign accept = (state == IDLE) && msg_valid;
  assign drop   = abort && (state != IDLE);
  // abort beats w_ack in DONE, so a dropped schedule is never counted
  assign retire = (state == DONE) && w_ack && !abort;

  w_index_counter #(
    .WIDTH    (IW),
    .LOAD_VAL (BLOCK_WORDS),
    .LAST_VAL (W_LENGTH - 1)
  ) u_index (
    .clock (clock),
    .reset (reset),
    .clear (drop || retire),
    .load  (accept),
    .inc   (state == EXPAND),
    .count (index),
    .last  (idx_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      blocks_done <= '0;
    end else if (drop) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:   if (msg_valid) state <= LOAD;
        LOAD:   state <= EXPAND;
        EXPAND: if (idx_last) state <= DONE;
        DONE: begin
          if (w_ack) begin
            state       <= IDLE;
            blocks_done <= blocks_done + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign msg_ready          = (state == IDLE);
  assign load_block         = (state == LOAD);
  assign exp_enable         = (state == EXPAND);
  assign w_ready            = (state == DONE);
  assign busy               = (state != IDLE);
  assign exp_index          = index;
  assign exp_index_complete = (index == IW'(W_LENGTH));

endmodule

// File: tb/tb_w_schedule_ctrl.sv
// Bench for w_schedule_ctrl: directed table, corner sequences, and
// random traffic checked every cycle against a block-age model.
module tb_w_schedule_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       msg_valid;
  logic       msg_ready;
  logic       load_block;
  logic       exp_enable;
  logic [6:0] exp_index;
  logic       exp_index_complete;
  logic       abort;
  logic       w_ready;
  logic       w_ack;
  logic       busy;
  logic [3:0] blocks_done;

  int passed = 0;
  int total  = 0;

  // model: age<0 idle, 1 = LOAD cycle, 2..49 expand, 50 = holding
  int age = -1;
  int cnt = 0;

  always #5 clock = ~clock;

  w_schedule_ctrl #(
    .W_LENGTH    (64),
    .BLOCK_WORDS (16),
    .CNT_WIDTH   (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .msg_valid          (msg_valid),
    .msg_ready          (msg_ready),
    .load_block         (load_block),
    .exp_enable         (exp_enable),
    .exp_index          (exp_index),
    .exp_index_complete (exp_index_complete),
    .abort              (abort),
    .w_ready            (w_ready),
    .w_ack              (w_ack),
    .busy               (busy),
    .blocks_done        (blocks_done)
  );

  function automatic logic [16:0] model_vec(int a, int c);
    logic mr, lb, ee, cp, wr, bz;
    logic [6:0] ix;
    mr = 0; lb = 0; ee = 0; cp = 0; wr = 0; bz = 1; ix = 0;
    if (a < 0) begin
      mr = 1; bz = 0;
    end else if (a == 1) begin
      lb = 1; ix = 7'd16;
    end else if (a < 50) begin
      ee = 1; ix = 7'(a + 14);
    end else begin
      wr = 1; cp = 1; ix = 7'd64;
    end
    return {mr, lb, ee, ix, cp, wr, bz, 4'(c)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {msg_ready, load_block, exp_enable, exp_index,
            exp_index_complete, w_ready, busy, blocks_done};
  endfunction

  task automatic check(input string nm, input logic [16:0] got,
                       input logic [16:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h (age %0d)", nm, got, want, age);
  endtask

  task automatic cycle(input logic v, input logic a,
                       input logic ab, input logic r);
    msg_valid = v; w_ack = a; abort = ab; reset = r;
    @(posedge clock);
    if (r) begin
      age = -1; cnt = 0;
    end else if (age < 0) begin
      if (v) age = 1;
    end else if (ab) begin
      age = -1;
    end else if (age >= 50) begin
      if (a) begin
        age = -1; cnt = (cnt + 1) % 16;
      end
    end else begin
      age++;
    end
    @(negedge clock);
    check("model", dut_vec(), model_vec(age, cnt));
    if (msg_ready && busy) check("ready_busy", 17'd1, 17'd0);
  endtask

  typedef struct {
    int         n;
    logic       v, a, ab, r;
    logic [6:0] ix;
    logic       wr, bz;
    logic [3:0] bd;
  } vec_t;

  vec_t tbl[17];
  int   loads[$];
  int   cyc;

  initial begin
    // {cycles, valid, ack, abort, reset, index, w_ready, busy, blocks}
    tbl[0]  = '{1,  0, 0, 0, 1, 7'd0,  0, 0, 4'd0};
    tbl[1]  = '{1,  1, 0, 0, 0, 7'd16, 0, 1, 4'd0};
    tbl[2]  = '{1,  0, 0, 0, 0, 7'd16, 0, 1, 4'd0};
    tbl[3]  = '{10, 0, 1, 0, 0, 7'd26, 0, 1, 4'd0};
    tbl[4]  = '{37, 0, 0, 0, 0, 7'd63, 0, 1, 4'd0};
    tbl[5]  = '{1,  0, 0, 0, 0, 7'd64, 1, 1, 4'd0};
    tbl[6]  = '{2,  1, 0, 0, 0, 7'd64, 1, 1, 4'd0};
    tbl[7]  = '{1,  0, 1, 1, 0, 7'd0,  0, 0, 4'd0};
    tbl[8]  = '{1,  1, 0, 0, 0, 7'd16, 0, 1, 4'd0};
    tbl[9]  = '{15, 0, 0, 0, 0, 7'd30, 0, 1, 4'd0};
    tbl[10] = '{1,  0, 0, 1, 0, 7'd0,  0, 0, 4'd0};
    tbl[11] = '{1,  1, 0, 0, 0, 7'd16, 0, 1, 4'd0};
    tbl[12] = '{49, 0, 0, 0, 0, 7'd64, 1, 1, 4'd0};
    tbl[13] = '{1,  0, 1, 0, 0, 7'd0,  0, 0, 4'd1};
    tbl[14] = '{1,  1, 0, 0, 0, 7'd16, 0, 1, 4'd1};
    tbl[15] = '{25, 0, 0, 0, 0, 7'd40, 0, 1, 4'd1};
    tbl[16] = '{1,  1, 1, 1, 1, 7'd0,  0, 0, 4'd0};

    msg_valid = 0; w_ack = 0; abort = 0; reset = 1;

    for (int i = 0; i < 17; i++) begin
      repeat (tbl[i].n) cycle(tbl[i].v, tbl[i].a, tbl[i].ab, tbl[i].r);
      check($sformatf("tbl%0d", i),
            17'({exp_index, w_ready, busy, blocks_done}),
            17'({tbl[i].ix, tbl[i].wr, tbl[i].bz, tbl[i].bd}));
    end
    check("reset_vec", dut_vec(), 17'({1'b1, 16'd0}));

    // back-to-back: valid and ack held high for three blocks
    cyc = 0;
    repeat (153) begin
      cycle(1, 1, 0, 0);
      cyc++;
      if (load_block) loads.push_back(cyc);
    end
    check("b2b_count", 17'(blocks_done), 17'd3);
    check("b2b_loads", 17'(loads.size()), 17'd3);
    if (loads.size() == 3) begin
      check("b2b_gap1", 17'(loads[1] - loads[0]), 17'd51);
      check("b2b_gap2", 17'(loads[2] - loads[1]), 17'd51);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end

    // counter wrap: 17 acknowledged blocks on a 4-bit count
    cycle(0, 0, 0, 1);
    repeat (17 * 51) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("wrap_count", 17'(blocks_done), 17'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/w_schedule_ctrl.md
# w_schedule_ctrl

Sequencing controller for the SHA-256 message-schedule expansion datapath. Accepts one 512-bit message block per handshake and pulses the datapath to latch W0..W15. It then steps the expansion index from 16 to 63, one word per cycle, and holds the completed 64-word schedule until the compression stage acknowledges it. Sits between the message padder/block buffer and the W-expansion and compression datapaths.

## Interface
Parameters:
- W_LENGTH, 64, total schedule words per block
- BLOCK_WORDS, 16, words loaded directly from the message block
- CNT_WIDTH, 32, width of the completed-block counter

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; one clock; forces IDLE
- msg_valid  in  1  upstream has a 512-bit block ready
- msg_ready  out  1  controller can accept a block (IDLE only)
- load_block  out  1  one-cycle pulse: datapath latches block into W0..W15
- exp_enable  out  1  expansion datapath enable
- exp_index  out  $clog2(W_LENGTH)+1  index of word being produced (16..63), 64 when finished
- exp_index_complete  out  1  high when exp_index == W_LENGTH
- abort  in  1  synchronous abandon of current block
- w_ready  out  1  full schedule valid for consumer
- w_ack  in  1  consumer has taken the schedule
- busy  out  1  state != IDLE
- blocks_done  out  CNT_WIDTH  count of acknowledged schedules

## Operation
- States:
  - IDLE: msg_ready=1. On msg_valid=1, go to LOAD.
  - LOAD: load_block=1, exp_index=16. Always go to EXPAND.
  - EXPAND: exp_enable=1, exp_index increments by 1 per cycle from 16. At exp_index==63, go to DONE.
  - DONE: exp_index=64, exp_index_complete=1, w_ready=1, exp_enable=0. On w_ack=1, go to IDLE and increment blocks_done.
- All outputs decode from registered state/index; no combinational input-to-output path.
- abort=1 in LOAD, EXPAND or DONE: next state IDLE, exp_index=0, blocks_done unchanged. abort in IDLE has no effect.
- abort and w_ack both high in DONE: abort wins; no count.
- w_ack outside DONE is ignored. msg_valid outside IDLE is ignored; upstream holds it.
- blocks_done wraps from 2^CNT_WIDTH-1 to 0.
- Index arithmetic is unsigned, width $clog2(W_LENGTH)+1. The index never exceeds 64.

## Timing
- Reset values (cycle after reset sampled high):
  - state=IDLE, msg_ready=1
  - load_block=0, exp_enable=0, exp_index=0, exp_index_complete=0
  - w_ready=0, busy=0, blocks_done=0
- Reset has priority over abort and all handshakes. Reset mid-EXPAND returns to IDLE next edge.
- Handshake accepted at edge T (msg_valid & msg_ready):
  - cycle T+1: LOAD
  - cycles T+2..T+49: EXPAND, 48 cycles, exp_index 16..63
  - cycle T+50: DONE, w_ready=1
- Minimum block-to-block interval: 51 cycles (ack in first DONE cycle, IDLE, then accept).
- w_ready stays high until w_ack or abort.

## Structure
- Shared package sha256_pkg holds:
  - state enum (IDLE, LOAD, EXPAND, DONE)
  - constants W_FIRST_EXP=16, W_LAST=63, W_LENGTH=64
- One natural sub-module, w_index_counter: loadable 7-bit counter with load-16, increment, clear and terminal-at-63 flag.
- The FSM and blocks_done counter stay in the top module.

## Test plan
- Reset then single block: msg_valid=1 at T → load_block at T+1; exp_index 16..63 at T+2..T+49; w_ready=1, exp_index=64 at T+50. w_ack at T+52 → IDLE at T+53, blocks_done=1.
- Back-to-back: msg_valid held high across 3 blocks with immediate w_ack → accepts 51 cycles apart, blocks_done=3, msg_ready low whenever busy=1.
- abort at exp_index=30 → next cycle IDLE, exp_index=0, exp_enable=0, blocks_done unchanged; the next block restarts at 16.
- Reset at exp_index=40 with w_ack and abort also high → all outputs at reset values next cycle.
- Stray w_ack in EXPAND and abort+w_ack together in DONE → no state change, and no count, respectively.
- blocks_done preset near wrap via CNT_WIDTH=4, 17 blocks acknowledged → blocks_done=1.
